// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade: NSEC cascaded Direct-Form-I biquad sections sharing one
// multiplier-accumulator. An FSM walks through each section in order
// (5 MAC cycles, then 1 update cycle). The coefficients can be written at run
// time while the FSM is idle.
// Optional build macro: IIR_SAT_EN. When it is defined, each section output
// saturates to the DW range. When it is undefined, each section output wraps
// (two's complement) to DW bits.
module iir_biquad_cascade #(
    parameter int DW   = 18,
    parameter int CW   = 18,
    parameter int FRAC = 16,
    parameter int NSEC = 2,
    parameter int AW   = DW + CW + 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DW-1:0]               din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic [DW-1:0]               dout,
    output logic                        dout_valid,
    input  logic                        coef_wr,
    input  logic [$clog2(5*NSEC)-1:0]   coef_addr,
    input  logic [CW-1:0]               coef_data,
    input  logic                        clr_state,
    output logic                        busy
);

    localparam int NC  = 5 * NSEC;
    localparam int CAW = $clog2(NC);
    localparam int SW  = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int PW  = DW + CW;

    localparam logic [CAW-1:0] NC_L     = CAW'(NC);
    localparam logic [SW-1:0]  LAST_SEC = SW'(NSEC - 1);
    localparam logic [CW-1:0]  B0_ONE   = CW'(1) << FRAC;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_UPD} state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          sec_q, sec_d;
    logic [2:0]             k_q, k_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [DW-1:0]   xin_q, xin_d;
    logic [DW-1:0]          dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;

    // Read-side views of the per-coefficient and per-section registers
    logic signed [CW-1:0]   coef_q [NC];
    logic signed [DW-1:0]   x1_q [NSEC];
    logic signed [DW-1:0]   x2_q [NSEC];
    logic signed [DW-1:0]   y1_q [NSEC];
    logic signed [DW-1:0]   y2_q [NSEC];

    logic                   idle;
    logic                   accept;
    logic                   clr_now;
    logic                   coef_we;
    logic [CAW-1:0]         cidx;
    logic signed [CW-1:0]   coef_sel;
    logic signed [DW-1:0]   opnd;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [DW-1:0]   y_sec;

    assign idle       = (state_q == S_IDLE);
    // clr_state wins over a same-cycle sample, so the handshake is closed while it is high
    assign din_ready  = idle && !clr_state;
    assign accept     = din_valid && din_ready;
    assign clr_now    = idle && clr_state;
    assign coef_we    = coef_wr && idle && (coef_addr < NC_L);
    assign busy       = !idle;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

    genvar gi;

    // Coefficient registers: b0 resets to unity, so the filter starts as a passthrough
    for (gi = 0; gi < NC; gi++) begin : g_coef
        localparam logic [CW-1:0] RST_VAL = (gi % 5 == 0) ? B0_ONE : '0;
        logic [CW-1:0] c_q, c_d;

        // Take the write only when it targets this slot
        always_comb begin
            c_d = c_q;
            if (coef_we && (coef_addr == CAW'(gi))) begin
                c_d = coef_data;
            end
        end

        // Coefficient flop
        always_ff @(posedge clk) begin
            if (rst) begin
                c_q <= RST_VAL;
            end else begin
                c_q <= c_d;
            end
        end

        assign coef_q[gi] = c_q;
    end

    // Per-section delay lines, shifted in that section's update cycle
    for (gi = 0; gi < NSEC; gi++) begin : g_sec
        logic signed [DW-1:0] hx1_q, hx1_d, hx2_q, hx2_d;
        logic signed [DW-1:0] hy1_q, hy1_d, hy2_q, hy2_d;
        logic                 upd_here;

        assign upd_here = (state_q == S_UPD) && (sec_q == SW'(gi));

        // A clear, or a shift of the input and output histories for this section
        always_comb begin
            hx1_d = hx1_q;
            hx2_d = hx2_q;
            hy1_d = hy1_q;
            hy2_d = hy2_q;
            if (clr_now) begin
                hx1_d = '0;
                hx2_d = '0;
                hy1_d = '0;
                hy2_d = '0;
            end else if (upd_here) begin
                hx2_d = hx1_q;
                hx1_d = xin_q;
                hy2_d = hy1_q;
                hy1_d = y_sec;
            end
        end

        // History flops
        always_ff @(posedge clk) begin
            if (rst) begin
                hx1_q <= '0;
                hx2_q <= '0;
                hy1_q <= '0;
                hy2_q <= '0;
            end else begin
                hx1_q <= hx1_d;
                hx2_q <= hx2_d;
                hy1_q <= hy1_d;
                hy2_q <= hy2_d;
            end
        end

        assign x1_q[gi] = hx1_q;
        assign x2_q[gi] = hx2_q;
        assign y1_q[gi] = hy1_q;
        assign y2_q[gi] = hy2_q;
    end

    // Shared multiplier: k selects the term (b0*x, b1*x1, b2*x2, a1*y1, a2*y2)
    always_comb begin
        cidx     = CAW'(sec_q) * CAW'(5) + CAW'(k_q);
        coef_sel = coef_q[cidx];
        case (k_q)
            3'd0:    opnd = xin_q;
            3'd1:    opnd = x1_q[sec_q];
            3'd2:    opnd = x2_q[sec_q];
            3'd3:    opnd = y1_q[sec_q];
            default: opnd = y2_q[sec_q];
        endcase
        prod     = coef_sel * opnd;
        prod_ext = {{(AW - PW){prod[PW-1]}}, prod};
    end

`ifdef IIR_SAT_EN
    logic signed [AW-1:0] acc_shift;

    // Floor-scale the accumulator, then clamp it to the DW range when the upper bits disagree
    always_comb begin
        acc_shift = acc_q >>> FRAC;
        if ((&acc_shift[AW-1:DW-1]) || !(|acc_shift[AW-1:DW-1])) begin
            y_sec = acc_shift[DW-1:0];
        end else if (acc_shift[AW-1]) begin
            y_sec = {1'b1, {(DW - 1){1'b0}}};
        end else begin
            y_sec = {1'b0, {(DW - 1){1'b1}}};
        end
    end
`else
    // Floor-scale the accumulator and keep the low DW bits (wraparound)
    always_comb begin
        y_sec = DW'(acc_q >>> FRAC);
    end
`endif

    // Sequencer next state: accept in IDLE, five MAC steps, then update or finish
    always_comb begin
        state_d      = state_q;
        sec_d        = sec_q;
        k_d          = k_q;
        acc_d        = acc_q;
        xin_d        = xin_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    xin_d   = $signed(din);
                    sec_d   = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (k_q == 3'd0) begin
                    acc_d = prod_ext;
                end else if (k_q < 3'd3) begin
                    acc_d = acc_q + prod_ext;
                end else begin
                    acc_d = acc_q - prod_ext;
                end
                if (k_q == 3'd4) begin
                    state_d = S_UPD;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_UPD: begin
                // The section output becomes the next section's input
                xin_d = y_sec;
                if (sec_q != LAST_SEC) begin
                    sec_d   = sec_q + SW'(1);
                    k_d     = '0;
                    state_d = S_MAC;
                end else begin
                    dout_d       = y_sec;
                    dout_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer and output registers; reset abandons any sample in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sec_q        <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            xin_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_q        <= sec_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            xin_q        <= xin_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

endmodule

// File: doc/iir_biquad_cascade.md
Name: iir_biquad_cascade

Overview:
Parametrised successor to the team's single 2nd-order IIR. Runs NSEC Direct-Form-I biquad sections in cascade, time-multiplexed onto one shared multiplier-accumulator under an FSM. Coefficients are run-time loadable through a register-write port. Has a valid/ready input handshake and optional output saturation. Sits in the sample-rate datapath between the ADC front-end and downstream decimation/detection.

Parameters:
DW, 18, sample width (signed, two's complement) for din, dout and section histories
CW, 18, coefficient width (signed)
FRAC, 16, coefficient fractional bits (Q(CW-FRAC).FRAC)
NSEC, 2, number of cascaded biquad sections (1..8)
AW, DW+CW+4, accumulator width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
din  in  DW  input sample, signed
din_valid  in  1  din qualifier
din_ready  out  1  high only in IDLE; sample accepted on din_valid&&din_ready
dout  out  DW  filtered output sample, signed, registered
dout_valid  out  1  one-cycle pulse when dout updates
coef_wr  in  1  coefficient write strobe
coef_addr  in  $clog2(5*NSEC)  addr = sec*5 + {0:b0,1:b1,2:b2,3:a1,4:a2}
coef_data  in  CW  coefficient value, signed
clr_state  in  1  synchronous clear of all section histories
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (rst=1 at edge): FSM->IDLE; dout=0, dout_valid=0, busy=0; all x1,x2,y1,y2 histories=0; coefficients: b0=2^FRAC, all others 0 (identity passthrough). Reset mid-sample aborts it; no dout_valid.
- Section equation: acc = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2 (products DW+CW bits, sign-extended to AW); y = acc >>> FRAC (arithmetic shift, floor), then reduced to DW bits (truncate or saturate, see Optional Feature).
- FSM states: IDLE, MAC, UPD.
  - IDLE: din_ready=1. On accept: latch din as section input, sec=0, k=0, go to MAC.
  - MAC: 5 cycles, k=0..4, one product per cycle. Order: b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2. k=0 loads acc; k=1..4 accumulate. After k=4 go to UPD.
  - UPD: compute y; update histories (x2<=x1, x1<=x, y2<=y1, y1<=y); y becomes the input of the next section. If sec<NSEC-1: sec++, go to MAC. Else register dout<=y, pulse dout_valid next cycle, go to IDLE.
- Latency: sample accepted at edge T -> dout_valid high in cycle T+6*NSEC+1 (13 for NSEC=2). Same cycle is IDLE with din_ready=1, so max throughput is 1 sample per 6*NSEC+1 cycles.
- din_valid while busy: not accepted; the source holds the sample. No dropping or queuing.
- Coefficient writes: applied only when FSM is IDLE. Write and din accept in the same cycle: the write lands, and that sample uses the new value. Writes while busy are dropped. coef_addr >= 5*NSEC is ignored.
- clr_state: honoured only in IDLE and takes priority over a same-cycle din accept (sample not accepted, din_ready forced 0 that cycle). Ignored while busy. Does not touch coefficients.
- Accumulator AW sized so 5 full-scale products cannot overflow; only the final DW reduction can overflow.

Optional Feature:
IIR_SAT_EN. Defined: each section output saturates to [-2^(DW-1), 2^(DW-1)-1] when acc>>>FRAC is out of range, and internal section outputs also saturate. Undefined: the low DW bits are kept (two's-complement wrap). No other behaviour differs.

Test Plan:
- Passthrough after reset, NSEC=2: din=1000 accepted at T -> dout=1000, dout_valid single pulse at T+13. din=-5 -> -5.
- Gain load: write addr0 (sec0 b0)=32768 (0.5) in IDLE; din=1000 -> dout=500. din=-3 -> dout=-2 (floor).
- Recursion: sec0 b0=65536, a1=-32768; impulse din=4096 then zeros -> outputs 4096, 2048, 1024, 512, ... Then pulse clr_state, din=0 -> 0.
- Overflow: sec0 b0=131071, din=100000 -> with IIR_SAT_EN dout=131071; without it dout=-62146.
- Handshake: din_valid held high with incrementing din -> accepted exactly once per 13 cycles, din_ready/busy complementary. A coef_wr issued while busy leaves the next output unchanged.
- Reset mid-sample: assert rst at T+7 -> no dout_valid, dout=0. Post-reset coefficients are identity: din=77 -> dout=77.
